rr_encoder_arbiter: RTL
=======================

Name: rr_encoder_arbiter

Overview:
Round-robin arbiter that shares one resource between 8 requesters. It produces a registered one-hot grant and the matching 3-bit encoded index, so the grant bus follows the same in→out mapping as the team's 8:3 encoder. A hold-time limit stops any single requester from starving the others. It sits between the requester ports and the shared datapath; gnt_idx drives the datapath mux select.

Parameters:
N, 8, number of requesters (fixed at 8 for this revision)
IDX_W, 3, width of encoded grant index (log2 N)
MAX_HOLD, 4, max consecutive grant cycles while others wait; 0 disables the limit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbiter enable; low blocks new grants and revokes the current one
req  input  8  request lines, bit i = requester i; level-held for the whole transaction
gnt  output  8  one-hot grant, registered; all-zero when no grant
gnt_idx  output  3  binary index of the set gnt bit; 0 when gnt_valid=0
gnt_valid  output  1  high whenever gnt is non-zero
preempt  output  1  one-cycle pulse when a grant is revoked by hold-limit timeout

Behaviour:
- Reset (async assert, sync release): gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Applies mid-grant with no wait for the current edge.
- Invariants: gnt is one-hot or zero. gnt_idx == encode(gnt). gnt_valid == |gnt.
- ptr (3b) is the highest-priority index. The search order is ptr, ptr+1, …, 7, 0, …, ptr-1, with wrap mod 8.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and |req, the winner is the first set req bit in search order.
  - Next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency is 1 cycle from a sampled request to the grant.
  - Otherwise remain in IDLE with outputs at zero.
- GRANT (cur = gnt_idx), evaluated each edge in this priority order:
  1. en=0: gnt=0, valid=0, idx=0, ptr=cur+1, state=IDLE, preempt=0.
  2. req[cur]=0 (release): same output clear, ptr=cur+1, state=IDLE.
  3. Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other req bit set. Clear the grant, ptr=cur+1, preempt=1 for this one cycle, state=IDLE.
  4. Otherwise: hold the grant. hold_cnt increments and saturates at MAX_HOLD-1.
- Any grant end always gives at least one cycle with gnt=0 before the next grant (bus turnaround). No direct GRANT→GRANT handoff.
- With the hold limit reached and no competitor, the grant is kept indefinitely, with no preempt.
- A preempted requester that still has req high competes normally. It has lowest priority next because ptr=cur+1.
- req changes on non-granted lines during GRANT are ignored until the next IDLE arbitration.
- preempt is registered and is 0 in every cycle except the one following the timeout edge.

Decomposition:
- Shared include arb_defs.vh holds:
  - N, IDX_W
  - state encodings IDLE=1'b0, GRANT=1'b1
  - the default MAX_HOLD
- One combinational sub-module, rr_priority_pick:
  - inputs: req[7:0], ptr[2:0]
  - outputs: any, win_idx[2:0]
  - method: rotate req right by ptr, fixed priority-encode, add ptr mod 8
- The top module holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset: apply req=0x01, en=1 → gnt=0x01, idx=0 one edge later. Then pull rst_n=0 between edges → gnt=0, gnt_valid=0 immediately. Release reset with req=0x01 → grant returns one edge later.
2. Rotation/timeout: MAX_HOLD=4, en=1, req=8'b1000_0101 held constant → idx 0 for 4 cycles, preempt pulse, gap, idx 2 for 4 cycles, preempt, gap, idx 7, then 0. Repeats with no other values.
3. Release and wrap: req=0x10 → idx=4. Drop req[4] → gnt=0 next edge, ptr=5. Then req=0x11 → grant idx 0, since search goes 5,6,7,0.
4. No contention: MAX_HOLD=4, req=0x08 held 10 cycles → gnt=0x08 for all cycles after the first, preempt never asserts.
5. Enable: en=0, req=0xFF for 5 cycles → gnt=0. Set en=1 → idx=ptr (0 after reset) one edge later. Drop en mid-grant → gnt=0 next edge, preempt=0.
6. Invariant sweep: random req/en/rst_n for 2000 cycles → gnt always one-hot or zero, gnt_idx==encode(gnt), and no requester waits more than 7×(MAX_HOLD+1) cycles while continuously requesting.

Source files
------------

// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// Requester count and index width are fixed for this revision.
package rr_encoder_arbiter_pkg;

    localparam int N                = 8;
    localparam int IDX_W            = 3;
    localparam int DEFAULT_MAX_HOLD = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_encoder_arbiter_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// fixed-priority encode the lowest set bit, then rotate the index back.
module rr_priority_pick
    import rr_encoder_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> ptr);
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDX_W'(i);
            end
        end
        any     = |req;
        // IDX_W-bit add wraps mod N because N is a power of two
        win_idx = off + ptr;
    end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// index and a hold-time limit that preempts a holder while others are waiting.
//
// state | meaning
// IDLE  | no grant driven; arbitrate among requests when enabled
// GRANT | gnt/gnt_idx hold the current owner; watch release, enable, hold limit
module rr_encoder_arbiter
    import rr_encoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic HOLD_EN = (MAX_HOLD != 0);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic             any;
    logic [IDX_W-1:0] win_idx;
    logic             others_req;
    logic             timeout;

    rr_priority_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .any     (any),
        .win_idx (win_idx)
    );

    assign others_req = |(req & ~gnt);
    assign timeout    = HOLD_EN && (hold_cnt == HOLD_LAST) && others_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && any) begin
                        gnt       <= onehot(win_idx);
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Every grant end goes through IDLE, giving a one-cycle bus turnaround
                    if (!en || !req[gnt_idx] || timeout) begin
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        preempt   <= en && req[gnt_idx];
                        state     <= IDLE;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
